viterbi_job_sched: RTL and testbench

- Round-robin job scheduler that shares one Viterbi decoder core among R requesters.
- Each requester submits a job: a sequence length, then a stream of observation symbols.
- The scheduler grants one job at a time, pulses the decoder start, and passes the granted requester's observations to the decoder under a valid/take handshake.
- It waits for decoder done, then returns a tagged completion response before arbitrating again.

---
 rtl/viterbi_job_sched.sv | 228 ++++++++++++++++++++++
 tb/tb_viterbi_job_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_job_sched.sv
// ---------------------------------------------------------------------------
// viterbi_job_sched
//   Round-robin scheduler that shares one Viterbi decoder core among R
//   requesters. One job is granted at a time. The scheduler pulses the decoder
//   start and streams the granted requester's observations to the decoder.
//   When the decoder reports done, it returns a tagged completion response.
//
// Ports
//   clk, rst_n       clock; asynchronous active-low reset
//   req_valid/len    per-requester job request and length (slice r*LW +: LW)
//   req_ready        one-cycle registered grant pulse to the granted requester
//   obs_valid_in/    per-requester observation stream (slice r*SW +: SW)
//   obs_data_in
//   obs_ready_in     observation accepted (granted requester only)
//   dec_start        one-cycle decoder start pulse
//   dec_length       length of the current job
//   dec_obs(_valid)  observation forwarded to the decoder
//   dec_obs_take     decoder consumes dec_obs this cycle
//   dec_done         decoder finished (honoured only while waiting)
//   rsp_*            completion response (id, error) with valid/ready
//   busy             scheduler is not idle
//   dec_abort        watchdog abort pulse (VITERBI_SCHED_TIMEOUT_EN only)
//
// Build option
//   VITERBI_SCHED_TIMEOUT_EN : adds a FEED/WAIT watchdog (TO_CYCLES), the
//   dec_abort port and an error response on expiry.
// ---------------------------------------------------------------------------
module viterbi_job_sched #(
  parameter int R = 4,
  parameter int N = 16,
  parameter int K = 3,
`ifdef VITERBI_SCHED_TIMEOUT_EN
  parameter int TO_CYCLES = 1024,
`endif
  localparam int LW = $clog2(N),
  localparam int SW = $clog2(K),
  localparam int RW = $clog2(R)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [R-1:0]    req_valid,
  input  logic [R*LW-1:0] req_len,
  output logic [R-1:0]    req_ready,
  input  logic [R-1:0]    obs_valid_in,
  input  logic [R*SW-1:0] obs_data_in,
  output logic [R-1:0]    obs_ready_in,
  output logic            dec_start,
  output logic [LW-1:0]   dec_length,
  output logic [SW-1:0]   dec_obs,
  output logic            dec_obs_valid,
  input  logic            dec_obs_take,
  input  logic            dec_done,
  output logic            rsp_valid,
  output logic [RW-1:0]   rsp_id,
  output logic            rsp_err,
  input  logic            rsp_ready,
  output logic            busy
`ifdef VITERBI_SCHED_TIMEOUT_EN
  ,
  output logic            dec_abort
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_FEED, S_WAIT, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   ptr_q, ptr_d;
  logic [RW-1:0]   g_q, g_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [R-1:0]    req_ready_q, req_ready_d;

  logic            any_req;
  logic [RW-1:0]   pick;
  logic [LW-1:0]   pick_len;
  logic            xfer;

`ifdef VITERBI_SCHED_TIMEOUT_EN
  localparam int WW = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
  logic [WW-1:0]   wdog_q, wdog_d;
  logic            wdog_hit;
  assign wdog_hit = (wdog_q == WW'(TO_CYCLES - 1));
`endif

  // Round-robin search: first asserted request at or above the pointer,
  // wrapping modulo R.
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    for (int i = 0; i < R; i++) begin
      if (!any_req && req_valid[(int'(ptr_q) + i) % R]) begin
        any_req = 1'b1;
        pick    = RW'((int'(ptr_q) + i) % R);
      end
    end
    pick_len = req_len[pick*LW +: LW];
  end

  // Only a valid observation the decoder takes while feeding is a transfer.
  assign xfer = (state_q == S_FEED) && obs_valid_in[g_q] && dec_obs_take;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    g_d         = g_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    req_ready_d = '0;
`ifdef VITERBI_SCHED_TIMEOUT_EN
    wdog_d      = wdog_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          g_d         = pick;
          len_d       = pick_len;
          req_ready_d = R'(1) << pick;
          // A zero-length job is rejected without ever starting the decoder.
          if (pick_len == '0) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_FEED;
`ifdef VITERBI_SCHED_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      S_FEED: begin
        if (xfer) begin
          cnt_d = cnt_q + LW'(1);
          if ((cnt_q + LW'(1)) == len_q) state_d = S_WAIT;
`ifdef VITERBI_SCHED_TIMEOUT_EN
          wdog_d = '0;
`endif
        end
`ifdef VITERBI_SCHED_TIMEOUT_EN
        else if (wdog_hit) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
`endif
      end
      S_WAIT: begin
        if (dec_done) state_d = S_RESP;
`ifdef VITERBI_SCHED_TIMEOUT_EN
        else if (wdog_hit) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          ptr_d   = RW'((int'(g_q) + 1) % R);
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      g_q         <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      req_ready_q <= '0;
`ifdef VITERBI_SCHED_TIMEOUT_EN
      wdog_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      g_q         <= g_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
`ifdef VITERBI_SCHED_TIMEOUT_EN
      wdog_q      <= wdog_d;
`endif
    end
  end

  // The observation path is a combinational mux from the granted requester,
  // open only while feeding so nothing leaks from other requesters.
  always_comb begin
    dec_obs       = '0;
    dec_obs_valid = 1'b0;
    obs_ready_in  = '0;
    if (state_q == S_FEED) begin
      dec_obs       = obs_data_in[g_q*SW +: SW];
      dec_obs_valid = obs_valid_in[g_q];
      obs_ready_in  = dec_obs_take ? (R'(1) << g_q) : '0;
    end
  end

  assign req_ready  = req_ready_q;
  assign dec_start  = (state_q == S_START);
  assign dec_length = len_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_id     = rsp_valid ? g_q : '0;
  assign rsp_err    = err_q;
  assign busy       = (state_q != S_IDLE);

`ifdef VITERBI_SCHED_TIMEOUT_EN
  assign dec_abort = wdog_hit &&
                     (((state_q == S_FEED) && !xfer) ||
                      ((state_q == S_WAIT) && !dec_done));
`endif

endmodule

// File: tb/tb_viterbi_job_sched.sv
module tb_viterbi_job_sched;

   localparam int R  = 4;
   localparam int K  = 3;
   localparam int LW = 4;
   localparam int SW = 2;
   localparam int RW = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [R-1:0]    req_valid;
   logic [R*LW-1:0] req_len;
   logic [R-1:0]    req_ready;
   logic [R-1:0]    obs_valid_in;
   logic [R*SW-1:0] obs_data_in;
   logic [R-1:0]    obs_ready_in;
   logic            dec_start;
   logic [LW-1:0]   dec_length;
   logic [SW-1:0]   dec_obs;
   logic            dec_obs_valid;
   logic            dec_obs_take;
   logic            dec_done;
   logic            rsp_valid;
   logic [RW-1:0]   rsp_id;
   logic            rsp_err;
   logic            rsp_ready;
   logic            busy;

   int total = 0;
   int bad   = 0;

   viterbi_job_sched dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
      .obs_valid_in(obs_valid_in), .obs_data_in(obs_data_in),
      .obs_ready_in(obs_ready_in),
      .dec_start(dec_start), .dec_length(dec_length), .dec_obs(dec_obs),
      .dec_obs_valid(dec_obs_valid), .dec_obs_take(dec_obs_take),
      .dec_done(dec_done),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err),
      .rsp_ready(rsp_ready), .busy(busy)
   );

   // free-running 100 MHz clock
   always #5 clk = ~clk;

   typedef struct {
      logic [R-1:0] req;
      int           len;
      int           exp_id;
      logic         exp_err;
   } vec_t;

   vec_t tbl[9];

   // one comparison: counts it and reports a mismatch
   task automatic checkOutput(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0d expected=%0d", name, act, exp);
      end
   endtask

   // drives every DUT input, then lets combinational outputs settle
   task automatic applyStimulus(input logic [R-1:0] rv, input logic [R*LW-1:0] rl,
                                input logic [R-1:0] ov, input logic [R*SW-1:0] od,
                                input logic take, input logic done, input logic rr);
      req_valid    = rv;
      req_len      = rl;
      obs_valid_in = ov;
      obs_data_in  = od;
      dec_obs_take = take;
      dec_done     = done;
      rsp_ready    = rr;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int rrPick(input logic [R-1:0] req, input int p);
      for (int i = 0; i < R; i++)
         if (req[(p + i) % R]) return (p + i) % R;
      return -1;
   endfunction

   // one complete job from idle: grant, start, feed, done, response
   task automatic runTableJob(input vec_t v);
      logic [R*LW-1:0] lens;
      logic [R*SW-1:0] od;
      int waited;
      int id;
      int sym;
      id = v.exp_id;
      for (int r = 0; r < R; r++) lens[r*LW +: LW] = LW'(v.len);
      applyStimulus(v.req, lens, '0, '0, 1'b0, 1'b0, 1'b0);
      waited = 0;
      do begin
         tick();
         waited++;
      end while (req_ready == '0 && waited < 5);
      checkOutput("grant_onehot", int'(req_ready), 1 << id);
      checkOutput("grant_latency", waited, 1);
      applyStimulus('0, lens, '0, '0, 1'b0, 1'b0, 1'b0);
      if (!v.exp_err) begin
         checkOutput("dec_start", int'(dec_start), 1);
         checkOutput("dec_length", int'(dec_length), v.len);
         tick();
         for (int k = 0; k < v.len; k++) begin
            sym = (k + id) % K;
            od = '1;
            od[id*SW +: SW] = SW'(sym);
            applyStimulus('0, lens, '1, od, 1'b1, 1'b0, 1'b0);
            checkOutput("feed_obs", int'(dec_obs), sym);
            checkOutput("feed_ready", int'(obs_ready_in), 1 << id);
            tick();
         end
         applyStimulus('0, lens, '1, '1, 1'b1, 1'b0, 1'b0);
         checkOutput("wait_no_valid", int'(dec_obs_valid), 0);
         checkOutput("wait_busy", int'(busy), 1);
         applyStimulus('0, lens, '0, '0, 1'b0, 1'b1, 1'b0);
         tick();
      end else begin
         checkOutput("zero_len_no_start", int'(dec_start), 0);
      end
      applyStimulus('0, lens, '0, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("rsp_valid", int'(rsp_valid), 1);
      checkOutput("rsp_id", int'(rsp_id), id);
      checkOutput("rsp_err", int'(rsp_err), int'(v.exp_err));
      applyStimulus('0, lens, '0, '0, 1'b0, 1'b0, 1'b1);
      tick();
      applyStimulus('0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("idle_busy", int'(busy), 0);
      checkOutput("idle_rsp_err", int'(rsp_err), 0);
   endtask

   // random-phase state (job-level reference model)
   int              mptr;
   int              cur_g;
   int              jlen[R];
   logic [SW-1:0]   jsym[R][16];
   bit              has_job[R];
   int              idx, xfers, jobs_done, g;
   bit              start_seen, done_flag, expect_grant, feed_now, in_wait, exp_rv;
   logic [R-1:0]    grant_req, rv, ov;
   logic [R*LW-1:0] rl;
   logic [R*SW-1:0] od;
   logic            t, d, rr;

   initial begin
      tbl[0] = '{4'b0001,  1, 0, 1'b0};
      tbl[1] = '{4'b1111,  2, 1, 1'b0};
      tbl[2] = '{4'b0011,  0, 0, 1'b1};
      tbl[3] = '{4'b0100,  3, 2, 1'b0};
      tbl[4] = '{4'b1001,  1, 3, 1'b0};
      tbl[5] = '{4'b1010,  0, 1, 1'b1};
      tbl[6] = '{4'b1111, 15, 2, 1'b0};
      tbl[7] = '{4'b0010,  2, 1, 1'b0};
      tbl[8] = '{4'b0001,  5, 0, 1'b0};

      rst_n = 1'b0;
      applyStimulus('0, '0, '1, '1, 1'b1, 1'b1, 1'b1);
      tick();
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_req_ready", int'(req_ready), 0);
      checkOutput("reset_rsp_valid", int'(rsp_valid), 0);
      checkOutput("reset_obs_ready", int'(obs_ready_in), 0);
      checkOutput("reset_dec_start", int'(dec_start), 0);
      rst_n = 1'b1;
      applyStimulus('0, '0, '0, '0, 1'b0, 1'b0, 1'b0);

      $display("[TB] table-driven jobs");
      for (int i = 0; i < 9; i++) runTableJob(tbl[i]);

      // backpressure on requester 1 (pointer now 1), len 2
      $display("[TB] backpressure sequence");
      begin
         logic [R*LW-1:0] lens;
         logic [3:0] take_p, val_p;
         int nx;
         int syms[2];
         take_p = 4'b1001;
         val_p  = 4'b1110;
         syms[0] = 2;
         syms[1] = 1;
         lens = '0;
         lens[1*LW +: LW] = LW'(2);
         applyStimulus(4'b0010, lens, '0, '0, 1'b0, 1'b0, 1'b0);
         tick();
         checkOutput("bp_grant", int'(req_ready), 2);
         applyStimulus('0, lens, '0, '0, 1'b0, 1'b0, 1'b0);
         tick();
         nx = 0;
         for (int c = 0; c < 8; c++) begin
            od = '0;
            od[1*SW +: SW] = SW'(syms[nx]);
            applyStimulus('0, lens, {2'b00, val_p[c%4], 1'b0}, od,
                          take_p[c%4], (c == 1), 1'b0);
            checkOutput("bp_valid", int'(dec_obs_valid), int'(val_p[c%4]));
            checkOutput("bp_ready", int'(obs_ready_in), take_p[c%4] ? 2 : 0);
            if (val_p[c%4]) checkOutput("bp_obs", int'(dec_obs), syms[nx]);
            if (val_p[c%4] && take_p[c%4]) nx++;
            tick();
         end
         applyStimulus('0, lens, '1, '0, 1'b1, 1'b0, 1'b0);
         checkOutput("bp_wait_at_len", int'(dec_obs_valid), 0);
         applyStimulus('0, lens, '0, '0, 1'b0, 1'b1, 1'b0);
         tick();
         for (int c = 0; c < 3; c++) begin
            applyStimulus('0, lens, '0, '0, 1'b0, 1'b0, 1'b0);
            checkOutput("bp_hold_valid", int'(rsp_valid), 1);
            checkOutput("bp_hold_id", int'(rsp_id), 1);
            checkOutput("bp_hold_err", int'(rsp_err), 0);
            tick();
         end
         applyStimulus('0, lens, '0, '0, 1'b0, 1'b0, 1'b1);
         tick();
         applyStimulus('0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
      end

      // reset in the middle of a 6-symbol job from requester 2 (pointer 2)
      $display("[TB] reset mid-feed");
      begin
         logic [R*LW-1:0] lens;
         lens = '0;
         lens[2*LW +: LW] = LW'(6);
         applyStimulus(4'b0100, lens, '0, '0, 1'b0, 1'b0, 1'b0);
         tick();
         checkOutput("rst_job_grant", int'(req_ready), 4);
         applyStimulus('0, lens, '0, '0, 1'b0, 1'b0, 1'b0);
         tick();
         for (int c = 0; c < 2; c++) begin
            applyStimulus('0, lens, 4'b0100, '0, 1'b1, 1'b0, 1'b0);
            tick();
         end
         applyStimulus('0, lens, 4'b0100, '0, 1'b1, 1'b0, 1'b0);
         checkOutput("rst_pre_feeding", int'(obs_ready_in), 4);
         rst_n = 1'b0;
         #1;
         checkOutput("rst_busy", int'(busy), 0);
         checkOutput("rst_obs_ready", int'(obs_ready_in), 0);
         checkOutput("rst_obs_valid", int'(dec_obs_valid), 0);
         checkOutput("rst_dec_length", int'(dec_length), 0);
         checkOutput("rst_rsp_valid", int'(rsp_valid), 0);
         tick();
         rst_n = 1'b1;
         applyStimulus('0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
         checkOutput("rst_no_response", int'(rsp_valid), 0);
         runTableJob('{4'b1010, 1, 1, 1'b0});
      end

      // randomized traffic against a job-level model
      $display("[TB] randomized traffic");
      mptr = 2;
      cur_g = -1;
      expect_grant = 0;
      jobs_done = 0;
      rv = '0;
      rl = '0;
      for (int r = 0; r < R; r++) begin
         has_job[r] = 0;
         jlen[r] = 0;
      end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         if (expect_grant) begin
            g = rrPick(grant_req, mptr);
            checkOutput("rand_grant", int'(req_ready), 1 << g);
            cur_g = g;
            rv[g] = 1'b0;
            idx = 0;
            xfers = 0;
            start_seen = 0;
            done_flag = 0;
            checkOutput("rand_start", int'(dec_start), int'(jlen[g] > 0));
            if (jlen[g] > 0) begin
               checkOutput("rand_length", int'(dec_length), jlen[g]);
               start_seen = 1;
            end
            feed_now = 0;
            in_wait = 0;
         end else begin
            checkOutput("rand_no_grant", int'(req_ready), 0);
            checkOutput("rand_no_start", int'(dec_start), 0);
            feed_now = (cur_g >= 0) && start_seen && (xfers < jlen[cur_g]);
            in_wait  = (cur_g >= 0) && start_seen && (xfers == jlen[cur_g]) && !done_flag;
         end
         for (int r = 0; r < R; r++) begin
            if (!has_job[r] && $urandom_range(0, 7) == 0) begin
               has_job[r] = 1;
               jlen[r] = ($urandom_range(0, 15) == 0) ? 15 : $urandom_range(0, 6);
               for (int k = 0; k < 16; k++) jsym[r][k] = SW'($urandom_range(0, K - 1));
               rv[r] = 1'b1;
               rl[r*LW +: LW] = LW'(jlen[r]);
            end
            ov[r] = 1'($urandom_range(0, 1));
            od[r*SW +: SW] = (r == cur_g) ? jsym[r][idx] : SW'($urandom_range(0, 3));
         end
         t  = ($urandom_range(0, 3) != 0);
         d  = ($urandom_range(0, 3) == 0);
         rr = 1'($urandom_range(0, 1));
         applyStimulus(rv, rl, ov, od, t, d, rr);
         if (feed_now) begin
            checkOutput("rand_obs_valid", int'(dec_obs_valid), int'(ov[cur_g]));
            checkOutput("rand_obs_ready", int'(obs_ready_in), t ? (1 << cur_g) : 0);
            if (ov[cur_g]) checkOutput("rand_obs", int'(dec_obs), int'(jsym[cur_g][idx]));
            if (ov[cur_g] && t) begin
               idx++;
               xfers++;
            end
         end else begin
            checkOutput("rand_obs_closed", int'(dec_obs_valid), 0);
            checkOutput("rand_ready_closed", int'(obs_ready_in), 0);
         end
         exp_rv = (cur_g >= 0) && ((jlen[cur_g] == 0) || done_flag);
         checkOutput("rand_busy", int'(busy), int'(cur_g >= 0));
         checkOutput("rand_rsp_valid", int'(rsp_valid), int'(exp_rv));
         if (exp_rv) begin
            checkOutput("rand_rsp_id", int'(rsp_id), cur_g);
            checkOutput("rand_rsp_err", int'(rsp_err), int'(jlen[cur_g] == 0));
         end
         if (in_wait && d) done_flag = 1;
         expect_grant = (cur_g < 0) && (rv != '0);
         grant_req = rv;
         if (exp_rv && rr) begin
            mptr = (cur_g + 1) % R;
            has_job[cur_g] = 0;
            cur_g = -1;
            jobs_done++;
         end
      end
      checkOutput("rand_progress", int'(jobs_done >= 20), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
